// File: rtl/bus_sequencer.sv
// Shared SRAM bus sequencer: 16-clock bus cycle split into video (0-3), SPI (4-7) and CPU (8-15) slots.
// Optional CPU_HALT_EN lets cpu_halt hand cycles 8-11 to a second SPI slot.
module bus_sequencer #(
    parameter int unsigned CPU_WE_START = 10,
    parameter int unsigned CPU_WE_END   = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_we,
    input  logic       cpu_ram_en,
    input  logic       cpu_readonly,
    input  logic       video_active,
    input  logic       spi_req,
    input  logic       spi_we,
    input  logic       cpu_halt,
    output logic [3:0] cycle,
    output logic [1:0] addr_sel,
    output logic       ram_oe,
    output logic       ram_we,
    output logic       cpu_phi2,
    output logic       cpu_en,
    output logic       video_strobe,
    output logic       spi_done
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} spi_state_t;

    localparam logic [3:0] WE_START = 4'(CPU_WE_START);
    localparam logic [3:0] WE_END   = 4'(CPU_WE_END);

    spi_state_t state, state_n;
    logic       slot2, slot2_n;
    logic       spi_wr, spi_wr_n;
    logic       halted_n;
    logic       sample2;
    logic [3:0] cycle_n, spi_end, spi_end_n;
    logic       spi_act, cpu_ok;

    logic [1:0] addr_sel_n;
    logic       ram_oe_n, ram_we_n, cpu_phi2_n, cpu_en_n, video_strobe_n, spi_done_n;

    assign cycle_n   = cycle + 4'd1;
    assign spi_end   = slot2 ? 4'd11 : 4'd7;
    assign spi_end_n = slot2_n ? 4'd11 : 4'd7;

`ifdef CPU_HALT_EN
    logic halted;

    // Halt is decided once per bus cycle, just before the CPU slot begins.
    always_comb begin
        halted_n = halted;
        if (cycle == 4'd7)
            halted_n = cpu_halt;
        else if (cycle == 4'd15)
            halted_n = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) halted <= 1'b0;
        else       halted <= halted_n;
    end

    assign sample2 = halted && (cycle == 4'd8);
`else
    logic unused_halt;
    assign unused_halt = cpu_halt;
    assign halted_n    = 1'b0;
    assign sample2     = 1'b0;
`endif

    // SPI handshake: a request is only taken from IDLE, and IDLE is re-entered
    // only after spi_req has been seen low, so one request yields one access.
    always_comb begin
        state_n  = state;
        slot2_n  = slot2;
        spi_wr_n = spi_wr;
        case (state)
            IDLE: begin
                if (spi_req && ((cycle == 4'd3) || sample2)) begin
                    state_n  = ACCESS;
                    slot2_n  = (cycle != 4'd3);
                    spi_wr_n = spi_we;
                end
            end
            ACCESS: begin
                if (cycle == spi_end)
                    state_n = spi_req ? DONE : IDLE;
            end
            DONE: begin
                if (!spi_req)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign spi_act = (state_n == ACCESS) && (cycle_n >= spi_end_n - 4'd3) && (cycle_n <= spi_end_n);
    assign cpu_ok  = cycle_n[3] && !halted_n;

    // Outputs are computed for the upcoming cycle and registered.
    always_comb begin
        addr_sel_n     = 2'd0;
        ram_oe_n       = 1'b0;
        ram_we_n       = 1'b0;
        cpu_phi2_n     = 1'b0;
        cpu_en_n       = 1'b0;
        video_strobe_n = 1'b0;
        spi_done_n     = 1'b0;
        if (cycle_n < 4'd4) begin
            addr_sel_n     = 2'd1;
            ram_oe_n       = video_active && (cycle_n != 4'd0);
            video_strobe_n = video_active && (cycle_n == 4'd3);
        end
        if (halted_n && cycle_n >= 4'd8 && cycle_n <= 4'd11)
            addr_sel_n = 2'd2;
        if (spi_act) begin
            addr_sel_n = 2'd2;
            if (spi_wr_n)
                ram_we_n = (cycle_n == spi_end_n - 4'd2) || (cycle_n == spi_end_n - 4'd1);
            else
                ram_oe_n = (cycle_n != spi_end_n - 4'd3);
            spi_done_n = (cycle_n == spi_end_n);
        end
        if (cpu_ok) begin
            cpu_phi2_n = 1'b1;
            cpu_en_n   = (cycle_n == 4'd15);
            if (cpu_we && cpu_ram_en && !cpu_readonly && cycle_n >= WE_START && cycle_n <= WE_END)
                ram_we_n = 1'b1;
            if (!cpu_we && cpu_ram_en && cycle_n >= 4'd9)
                ram_oe_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle        <= 4'd0;
            state        <= IDLE;
            slot2        <= 1'b0;
            spi_wr       <= 1'b0;
            addr_sel     <= 2'd0;
            ram_oe       <= 1'b0;
            ram_we       <= 1'b0;
            cpu_phi2     <= 1'b0;
            cpu_en       <= 1'b0;
            video_strobe <= 1'b0;
            spi_done     <= 1'b0;
        end else begin
            cycle        <= cycle_n;
            state        <= state_n;
            slot2        <= slot2_n;
            spi_wr       <= spi_wr_n;
            addr_sel     <= addr_sel_n;
            ram_oe       <= ram_oe_n;
            ram_we       <= ram_we_n;
            cpu_phi2     <= cpu_phi2_n;
            cpu_en       <= cpu_en_n;
            video_strobe <= video_strobe_n;
            spi_done     <= spi_done_n;
        end
    end
endmodule
